// File: rtl/branch_pht_pkg.sv
// Shared definitions for the branch pattern history table: counter encodings,
// reset state and default geometry.
package branch_pht_pkg;

   localparam int unsigned PHT_ENTRIES = 16;
   localparam int unsigned STAT_W      = 16;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } pht_state_e;

   localparam pht_state_e PHT_RESET_STATE = ST;

   function automatic logic state_taken(input pht_state_e s);
      return s[1];
   endfunction

endpackage

// File: rtl/branch_pht_stat.sv
// 16-bit saturating event counter used for branch and mispredict statistics.
module branch_pht_stat
   import branch_pht_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              inc_i,
   output logic [STAT_W-1:0] cnt_o
);

   logic [STAT_W-1:0] cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt <= '0;
      end else if (inc_i && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign cnt_o = cnt;

endmodule

// File: rtl/branch_pht.sv
// Two-bit saturating-counter branch predictor: combinational lookup in ID,
// one-cycle-later update from EX with write-first bypass, plus statistics.
module branch_pht
   import branch_pht_pkg::*;
#(
   parameter int unsigned ENTRIES = PHT_ENTRIES,
   parameter int unsigned IDX_W   = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] ID_pc_i,
   input  logic        ID_Branch_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [1:0]  EX_update_i,
   input  logic        EX_rbk_i,
   output logic        pred_taken_o,
   output logic [1:0]  ID_state_o,
   output logic [1:0]  EX_state_o,
   output logic [15:0] branch_cnt_o,
   output logic [15:0] mispred_cnt_o
);

   pht_state_e             pht [ENTRIES];
   logic [IDX_W-1:0]       id_idx;
   pht_state_e             id_state;
   pht_state_e             ex_update;
   logic                   ex_valid;
   logic [IDX_W-1:0]       ex_idx;
   pht_state_e             ex_state;
   logic                   bypass;
   logic                   unused_pc;

   assign id_idx    = ID_pc_i[IDX_W+1:2];
   assign unused_pc = ^{ID_pc_i[31:IDX_W+2], ID_pc_i[1:0]};
   assign ex_update = pht_state_e'(EX_update_i);

   // The entry being written this edge is forwarded so ID never sees stale state.
   assign bypass = ex_valid && (ex_idx == id_idx);

   always_comb begin
      id_state = pht[id_idx];
      if (bypass) begin
         id_state = ex_update;
      end
   end

   assign ID_state_o   = id_state;
   assign pred_taken_o = ID_Branch_i && state_taken(id_state);
   assign EX_state_o   = ex_valid ? ex_state : PHT_RESET_STATE;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ex_valid <= 1'b0;
         ex_idx   <= '0;
         ex_state <= PHT_RESET_STATE;
      end else begin
         ex_valid <= ID_Branch_i && !stall_i && !flush_i;
         ex_idx   <= id_idx;
         ex_state <= id_state;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            pht[i] <= PHT_RESET_STATE;
         end
      end else if (ex_valid) begin
         pht[ex_idx] <= ex_update;
      end
   end

   branch_pht_stat u_branch_stat (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (ex_valid),
      .cnt_o (branch_cnt_o)
   );

   branch_pht_stat u_mispred_stat (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (ex_valid && EX_rbk_i),
      .cnt_o (mispred_cnt_o)
   );

endmodule

// File: tb/tb_branch_pht.sv
// Directed bench for branch_pht: inputs change on the falling edge, outputs
// are checked shortly after, well away from the rising edge.
module tb_branch_pht;

   logic        clk_i;
   logic        rst_i;
   logic [31:0] ID_pc_i;
   logic        ID_Branch_i;
   logic        stall_i;
   logic        flush_i;
   logic [1:0]  EX_update_i;
   logic        EX_rbk_i;
   logic        pred_taken_o;
   logic [1:0]  ID_state_o;
   logic [1:0]  EX_state_o;
   logic [15:0] branch_cnt_o;
   logic [15:0] mispred_cnt_o;

   int unsigned checks;
   int unsigned errors;

   branch_pht #(
      .ENTRIES (16),
      .IDX_W   (4)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .ID_pc_i       (ID_pc_i),
      .ID_Branch_i   (ID_Branch_i),
      .stall_i       (stall_i),
      .flush_i       (flush_i),
      .EX_update_i   (EX_update_i),
      .EX_rbk_i      (EX_rbk_i),
      .pred_taken_o  (pred_taken_o),
      .ID_state_o    (ID_state_o),
      .EX_state_o    (EX_state_o),
      .branch_cnt_o  (branch_cnt_o),
      .mispred_cnt_o (mispred_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge, where the next cycle's inputs are driven.
   task automatic next_cycle();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic drive(input logic [31:0] pc, input logic br, input logic stl,
                        input logic fls, input logic [1:0] upd, input logic rbk);
      ID_pc_i     = pc;
      ID_Branch_i = br;
      stall_i     = stl;
      flush_i     = fls;
      EX_update_i = upd;
      EX_rbk_i    = rbk;
      #1;
   endtask

   task automatic peek(input string tag, input logic [31:0] pc, input logic [1:0] exp);
      ID_pc_i = pc;
      #1;
      check(tag, {30'd0, ID_state_o}, {30'd0, exp});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_i  = 1'b0;
      drive(32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

      check("rst_ex_state",   {30'd0, EX_state_o}, 32'h3);
      check("rst_branch_cnt", {16'd0, branch_cnt_o}, 32'h0);
      check("rst_mispred",    {16'd0, mispred_cnt_o}, 32'h0);

      // C0: release reset, first lookup of 0x40 (entry 0)
      @(negedge clk_i);
      rst_i = 1'b1;
      drive(32'h40, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
      check("c0_id_state", {30'd0, ID_state_o}, 32'h3);
      check("c0_pred",     {31'd0, pred_taken_o}, 32'h1);
      check("c0_ex_state", {30'd0, EX_state_o}, 32'h3);
      check("c0_cnt",      {16'd0, branch_cnt_o}, 32'h0);

      // C1: EX holds entry 0; lookup 0x44 (entry 1)
      next_cycle();
      drive(32'h44, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
      check("c1_ex_state", {30'd0, EX_state_o}, 32'h3);
      check("c1_id_state", {30'd0, ID_state_o}, 32'h3);

      // C2: EX entry 1 resolved not-taken -> 10, bypassed to the ID lookup
      next_cycle();
      drive(32'h44, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1);
      check("c2_ex_state", {30'd0, EX_state_o}, 32'h3);
      check("c2_bypass",   {30'd0, ID_state_o}, 32'h2);
      check("c2_pred",     {31'd0, pred_taken_o}, 32'h1);
      check("c2_cnt",      {16'd0, branch_cnt_o}, 32'h1);

      // C3: EX entry 1 resolved not-taken again -> 01; ID not a branch
      next_cycle();
      drive(32'h44, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
      check("c3_ex_state", {30'd0, EX_state_o}, 32'h2);
      check("c3_bypass",   {30'd0, ID_state_o}, 32'h1);
      check("c3_pred_nb",  {31'd0, pred_taken_o}, 32'h0);
      check("c3_cnt",      {16'd0, branch_cnt_o}, 32'h2);
      check("c3_mispred",  {16'd0, mispred_cnt_o}, 32'h1);

      // C4: EX bubble; only entry 1 changed; flushed branch issued
      next_cycle();
      drive(32'h44, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
      check("c4_ex_state", {30'd0, EX_state_o}, 32'h3);
      check("c4_id_state", {30'd0, ID_state_o}, 32'h1);
      check("c4_pred",     {31'd0, pred_taken_o}, 32'h0);
      check("c4_cnt",      {16'd0, branch_cnt_o}, 32'h3);
      check("c4_mispred",  {16'd0, mispred_cnt_o}, 32'h2);
      peek("c4_entry0", 32'h00, 2'b11);
      peek("c4_entry2", 32'h08, 2'b11);
      ID_pc_i = 32'h44;
      #1;

      // C5: flushed branch is a bubble; stalled branch issued
      next_cycle();
      drive(32'h44, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
      check("c5_ex_state", {30'd0, EX_state_o}, 32'h3);
      check("c5_no_write", {30'd0, ID_state_o}, 32'h1);
      check("c5_cnt",      {16'd0, branch_cnt_o}, 32'h3);
      check("c5_mispred",  {16'd0, mispred_cnt_o}, 32'h2);

      // C6: stalled branch is a bubble; issue branch at 0x0C (entry 3)
      next_cycle();
      drive(32'h44, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
      check("c6_ex_state", {30'd0, EX_state_o}, 32'h3);
      check("c6_no_write", {30'd0, ID_state_o}, 32'h1);
      check("c6_cnt",      {16'd0, branch_cnt_o}, 32'h3);
      drive(32'h0C, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);

      // C7: EX entry 3 updates to 00, visible in the same cycle; then issue 0x08
      next_cycle();
      drive(32'h0C, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
      check("c7_ex_state", {30'd0, EX_state_o}, 32'h3);
      check("c7_bypass",   {30'd0, ID_state_o}, 32'h0);
      check("c7_pred",     {31'd0, pred_taken_o}, 32'h0);
      drive(32'h08, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
      check("c7_entry2",   {30'd0, ID_state_o}, 32'h3);

      // C8: entry 3 written; EX entry 2 updates to 00
      next_cycle();
      drive(32'h0C, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
      check("c8_entry3", {30'd0, ID_state_o}, 32'h0);
      check("c8_cnt",    {16'd0, branch_cnt_o}, 32'h4);

      // C9: aliasing 0x48 onto entry 2
      next_cycle();
      drive(32'h48, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
      check("c9_alias",   {30'd0, ID_state_o}, 32'h0);
      check("c9_cnt",     {16'd0, branch_cnt_o}, 32'h5);
      check("c9_mispred", {16'd0, mispred_cnt_o}, 32'h4);
      peek("c9_entry1", 32'h04, 2'b01);
      peek("c9_entry0", 32'h40, 2'b11);

      // C10/C11: branch at 0x10 reaches EX, reset asserted mid-cycle
      drive(32'h10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
      next_cycle();
      drive(32'h10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
      check("c11_ex_state", {30'd0, EX_state_o}, 32'h3);
      rst_i = 1'b0;
      #1;
      check("async_ex_state", {30'd0, EX_state_o}, 32'h3);
      check("async_cnt",      {16'd0, branch_cnt_o}, 32'h0);
      check("async_mispred",  {16'd0, mispred_cnt_o}, 32'h0);
      peek("async_entry3", 32'h0C, 2'b11);

      @(negedge clk_i);
      rst_i = 1'b1;
      drive(32'h10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
      next_cycle();
      check("post_rst_entry4", {30'd0, ID_state_o}, 32'h3);
      check("post_rst_cnt",    {16'd0, branch_cnt_o}, 32'h0);
      peek("post_rst_entry1", 32'h04, 2'b11);

      // Saturation: continuous mispredicted branches
      drive(32'h20, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1);
      for (int i = 0; i < 10; i++) next_cycle();
      check("sat_partial_cnt",     {16'd0, branch_cnt_o}, 32'd9);
      check("sat_partial_mispred", {16'd0, mispred_cnt_o}, 32'd9);
      for (int i = 0; i < 65530; i++) next_cycle();
      ID_Branch_i = 1'b0;
      next_cycle();
      next_cycle();
      check("sat_cnt",     {16'd0, branch_cnt_o}, 32'hFFFF);
      check("sat_mispred", {16'd0, mispred_cnt_o}, 32'hFFFF);
      check("sat_entry8",  {30'd0, ID_state_o}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_pht.md
BRANCH_PHT -- requirements
Module: branch_pht

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of predictor entries (power of two, 4..64).
REQ-002 SHALL have parameter IDX_W, default 4, index width (log2 of ENTRIES).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ID_pc_i  input  32  PC of the instruction in ID.
REQ-006 SHALL have port ID_Branch_i  input  1  ID instruction is a conditional branch.
REQ-007 SHALL have port stall_i  input  1  hazard stall; bubble into EX.
REQ-008 SHALL have port flush_i  input  1  ID flush on mispredict; bubble into EX.
REQ-009 SHALL have port EX_update_i  input  2  next counter state for the EX branch, from the branch-update stage.
REQ-010 SHALL have port EX_rbk_i  input  1  EX branch mispredicted (rollback).
REQ-011 SHALL have port pred_taken_o  output  1  prediction for the ID branch.
REQ-012 SHALL have port ID_state_o  output  2  counter state read for the ID branch.
REQ-013 SHALL have port EX_state_o  output  2  registered counter state of the EX branch, to the branch-update stage.
REQ-014 SHALL have port branch_cnt_o  output  16  resolved-branch count.
REQ-015 SHALL have port mispred_cnt_o  output  16  mispredict count.

Function
REQ-016 SHALL hold ENTRIES 2-bit counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-017 SHALL form ID index as ID_pc_i[IDX_W+1:2]; bits [1:0] ignored.
REQ-018 SHALL drive ID_state_o combinationally as the indexed counter (zero-cycle read).
REQ-019 SHALL drive pred_taken_o = ID_Branch_i AND ID_state_o[1]; 0 when ID_Branch_i=0.
REQ-020 SHALL register EX_valid, EX_idx, EX_state on each edge from ID_Branch_i, ID index, ID_state_o.
REQ-021 SHALL load EX_valid=0 (bubble) when stall_i or flush_i is 1; flush_i and stall_i have equal effect; EX_idx/EX_state don't-care then.
REQ-022 SHALL drive EX_state_o = EX_state; 2'b11 when EX_valid=0.
REQ-023 SHALL write EX_update_i into entry EX_idx on the edge when EX_valid=1, exactly one write per resolved branch.
REQ-024 SHALL NOT write any entry when EX_valid=0, regardless of EX_update_i.
REQ-025 SHALL bypass: when EX_valid=1 and EX_idx equals ID index in the same cycle, ID_state_o and pred_taken_o use EX_update_i (write-first).
REQ-026 SHALL increment branch_cnt_o on each edge with EX_valid=1.
REQ-027 SHALL increment mispred_cnt_o on each edge with EX_valid=1 and EX_rbk_i=1.
REQ-028 SHALL saturate both counters at 16'hFFFF (no wrap).
REQ-029 SHALL give a one-cycle lookup-to-update latency: a branch looked up in cycle N is written at the end of cycle N+1.

Reset
REQ-030 SHALL, while rst_i=0, asynchronously set all counters to 2'b11, EX_valid=0, EX_idx=0, EX_state=2'b11, branch_cnt_o=0, mispred_cnt_o=0.
REQ-031 SHALL discard an in-flight EX branch on reset assertion mid-operation (no write after release).
REQ-032 SHALL resume lookups on the first rising edge after rst_i returns to 1.

Structure
REQ-033 SHALL place the state encodings (SNT, WNT, WT, ST), reset state 2'b11 and default ENTRIES in the shared CPU package.
REQ-034 SHALL use one sub-module, branch_pht_stat (16-bit saturating event counter), instantiated twice.

Verification
REQ-035 SHALL cover reset: rst_i=0 then 1, PC 0x40 branch -> ID_state_o=11, pred_taken_o=1, counters 0.
REQ-036 SHALL cover training: branch at 0x44 resolved not-taken twice (EX_update_i 10 then 01) -> next lookup ID_state_o=01, pred_taken_o=0, entry 1 only changed.
REQ-037 SHALL cover bypass: EX branch idx 3 with EX_update_i=00 while ID PC=0x0C -> ID_state_o=00 in that same cycle.
REQ-038 SHALL cover flush/stall: ID_Branch_i=1 with flush_i=1 (then separately stall_i=1) -> next cycle EX_valid=0, EX_state_o=11, no write, branch_cnt_o unchanged.
REQ-039 SHALL cover saturation: 65540 resolved mispredicts -> branch_cnt_o=mispred_cnt_o=16'hFFFF.
REQ-040 SHALL cover aliasing: PCs 0x08 and 0x48 (ENTRIES=16) -> update via one visible on lookup of the other.
